// File: rtl/inst_encoder_pkg.sv
// Shared types and field positions for the RV32I instruction encoder.
// The immediate-select coding matches the core's immediate generator.
package inst_encoder_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_SHIFT = 3'b101,
    IMM_R     = 3'b110,
    IMM_RSVD  = 3'b111
  } imm_sel_e;

  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

  // True when v[31:top] are all copies of the sign bit, i.e. v fits in a top+1 bit signed field.
  function automatic logic sext_ok(input logic [31:0] v, input int unsigned top);
    logic [31:0] s;
    s = $unsigned($signed(v) >>> top);
    return (s == 32'h0000_0000) || (s == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-input and encoded-word-output handshake bundle for inst_encoder.
// The encoder uses the slave view; the program-load path uses master.
interface inst_encoder_if #(
  parameter int Width = 32,
  parameter int AW    = 10
);
  import inst_encoder_pkg::*;

  logic             in_valid;
  logic             in_ready;
  imm_sel_e         imm_sel;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [Width-1:0] imm;
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] out_inst;
  logic             out_err;
  logic [AW-1:0]    out_addr;

  modport master (
    output in_valid, imm_sel, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err, out_addr
  );

  modport slave (
    input  in_valid, imm_sel, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, out_inst, out_err, out_addr
  );

endinterface

// File: rtl/inst_encoder_enc_fifo2.sv
// Two-entry synchronous FIFO with flush; full/empty come straight from registered count.
module enc_fifo2
  import inst_encoder_pkg::*;
#(
  parameter int            DW       = 8,
  parameter logic [DW-1:0] RST_DATA = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  logic [DW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == 2'd2);
  assign o_empty   = (r_count == 2'd0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= RST_DATA;
      r_mem[1] <= RST_DATA;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Packs decoded RV32I fields plus a full immediate into an instruction word,
// flags immediates that cannot round-trip, and queues {inst, err, addr}.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int          Width     = 32,
  parameter int          AW        = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          ERRW      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  inst_encoder_if.slave   bus,
  output logic [ERRW-1:0] err_cnt
);

  localparam int DW = Width + 1 + AW;
  localparam logic [DW-1:0] RST_ENTRY = {{Width{1'b0}}, 1'b0, AW'(BASE_ADDR)};

  logic [Width-1:0] w_inst;
  logic             w_err;
  logic [Width-1:0] w_imm;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic [DW-1:0]    w_head;
  logic [AW-1:0]    r_addr;
  logic [ERRW-1:0]  r_err_cnt;

  assign w_imm = bus.imm;

  always_comb begin
    w_inst = '0;
    w_err  = 1'b0;
    case (bus.imm_sel)
      IMM_I: begin
        w_inst[31:20]             = w_imm[11:0];
        w_inst[RS1_LSB +: 5]      = bus.rs1;
        w_inst[FUNCT3_LSB +: 3]   = bus.funct3;
        w_inst[RD_LSB +: 5]       = bus.rd;
        w_err                     = !sext_ok(w_imm, 11);
      end
      IMM_S: begin
        w_inst[31:25]             = w_imm[11:5];
        w_inst[RS2_LSB +: 5]      = bus.rs2;
        w_inst[RS1_LSB +: 5]      = bus.rs1;
        w_inst[FUNCT3_LSB +: 3]   = bus.funct3;
        w_inst[11:7]              = w_imm[4:0];
        w_err                     = !sext_ok(w_imm, 11);
      end
      IMM_B: begin
        w_inst[31]                = w_imm[12];
        w_inst[30:25]             = w_imm[10:5];
        w_inst[RS2_LSB +: 5]      = bus.rs2;
        w_inst[RS1_LSB +: 5]      = bus.rs1;
        w_inst[FUNCT3_LSB +: 3]   = bus.funct3;
        w_inst[11:8]              = w_imm[4:1];
        w_inst[7]                 = w_imm[11];
        w_err                     = w_imm[0] | !sext_ok(w_imm, 12);
      end
      IMM_J: begin
        w_inst[31]                = w_imm[20];
        w_inst[30:21]             = w_imm[10:1];
        w_inst[20]                = w_imm[11];
        w_inst[19:12]             = w_imm[19:12];
        w_inst[RD_LSB +: 5]       = bus.rd;
        w_err                     = w_imm[0] | !sext_ok(w_imm, 20);
      end
      IMM_U: begin
        w_inst[31:12]             = w_imm[31:12];
        w_inst[RD_LSB +: 5]       = bus.rd;
        w_err                     = (w_imm[11:0] != 12'h000);
      end
      IMM_SHIFT: begin
        w_inst[FUNCT7_LSB +: 7]   = bus.funct7;
        w_inst[24:20]             = w_imm[4:0];
        w_inst[RS1_LSB +: 5]      = bus.rs1;
        w_inst[FUNCT3_LSB +: 3]   = bus.funct3;
        w_inst[RD_LSB +: 5]       = bus.rd;
        w_err                     = (w_imm[31:5] != 27'h0);
      end
      IMM_R: begin
        w_inst[FUNCT7_LSB +: 7]   = bus.funct7;
        w_inst[RS2_LSB +: 5]      = bus.rs2;
        w_inst[RS1_LSB +: 5]      = bus.rs1;
        w_inst[FUNCT3_LSB +: 3]   = bus.funct3;
        w_inst[RD_LSB +: 5]       = bus.rd;
      end
      default: begin
        w_err = 1'b1;
      end
    endcase
    // Reserved select produces an all-zero word, opcode included.
    if (bus.imm_sel != IMM_RSVD) begin
      w_inst[6:0] = bus.opcode;
    end
  end

  assign bus.in_ready = ~w_full;
  assign w_push       = bus.in_valid & ~w_full & ~flush;

  enc_fifo2 #(
    .DW       (DW),
    .RST_DATA (RST_ENTRY)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_push  (w_push),
    .i_pop   (bus.out_ready),
    .i_data  ({w_inst, w_err, r_addr}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.out_valid = ~w_empty;
  assign {bus.out_inst, bus.out_err, bus.out_addr} = w_head;
  assign err_cnt = r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= AW'(BASE_ADDR);
      r_err_cnt <= '0;
    end else if (flush) begin
      r_addr    <= AW'(BASE_ADDR);
    end else if (w_push) begin
      r_addr <= r_addr + AW'(1);
      if (w_err && (r_err_cnt != {ERRW{1'b1}})) begin
        r_err_cnt <= r_err_cnt + ERRW'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: vector table through a scoreboard queue,
// plus hand-written backpressure, flush/wrap and asynchronous-reset sequences.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam int AW   = 2;
  localparam int ERRW = 3;

  typedef struct {
    logic [2:0]  sel;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0]   inst;
    logic          err;
    logic [AW-1:0] addr;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic [ERRW-1:0] err_cnt;

  inst_encoder_if #(.Width(32), .AW(AW)) bus ();

  inst_encoder #(
    .Width(32), .AW(AW), .BASE_ADDR(0), .ERRW(ERRW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  vec_t            tv [16];
  exp_t            q [$];
  logic [AW-1:0]   m_addr = '0;
  logic [ERRW-1:0] m_err  = '0;
  logic [31:0]     cur_inst;
  logic            cur_err;
  logic            acc;
  int              n_acc = 0;
  int              n_chk = 0;
  int              n_err = 0;

  function automatic vec_t mk(input logic [2:0] sel, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm,
                              input logic [31:0] ei, input logic ee);
    vec_t v;
    v.sel = sel; v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.exp_inst = ei; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    acc = 1'b0;
    if (flush) begin
      q.delete();
      m_addr = '0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_pop", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("inst", bus.out_inst, e.inst);
          chk("err", {31'd0, bus.out_err}, {31'd0, e.err});
          chk("addr", {30'd0, bus.out_addr}, {30'd0, e.addr});
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.inst = cur_inst; e.err = cur_err; e.addr = m_addr;
        q.push_back(e);
        m_addr = m_addr + 1'b1;
        if (cur_err && (m_err != {ERRW{1'b1}})) m_err = m_err + 1'b1;
        acc = 1'b1;
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i);
    bus.imm_sel = imm_sel_e'(tv[i].sel);
    bus.opcode  = tv[i].op;
    bus.funct3  = tv[i].f3;
    bus.funct7  = tv[i].f7;
    bus.rd      = tv[i].rd;
    bus.rs1     = tv[i].rs1;
    bus.rs2     = tv[i].rs2;
    bus.imm     = tv[i].imm;
    cur_inst    = tv[i].exp_inst;
    cur_err     = tv[i].exp_err;
  endtask

  task automatic send(input int i);
    int t;
    load(i);
    bus.in_valid = 1'b1;
    t = 0;
    do begin
      cyc();
      t++;
    end while (!acc && t < 50);
    chk("accepted", {31'd0, acc}, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    bus.out_ready = 1'b1;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      cyc();
      t++;
    end
    chk("drain_left", q.size(), 32'd0);
    chk("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    tv[0]  = mk(3'd0, 7'h13, 3'd0, 7'h00, 5'd1,  5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
    tv[1]  = mk(3'd1, 7'h23, 3'd2, 7'h00, 5'd31, 5'd1, 5'd2, 32'h00000008, 32'h0020A423, 1'b0);
    tv[2]  = mk(3'd4, 7'h37, 3'd7, 7'h00, 5'd5,  5'd3, 5'd0, 32'h12345000, 32'h123452B7, 1'b0);
    tv[3]  = mk(3'd2, 7'h63, 3'd0, 7'h00, 5'd0,  5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
    tv[4]  = mk(3'd3, 7'h6F, 3'd0, 7'h00, 5'd1,  5'd0, 5'd0, 32'h00000800, 32'h001000EF, 1'b0);
    tv[5]  = mk(3'd5, 7'h13, 3'd5, 7'h20, 5'd3,  5'd4, 5'd0, 32'h0000001F, 32'h41F25193, 1'b0);
    tv[6]  = mk(3'd6, 7'h33, 3'd0, 7'h20, 5'd5,  5'd6, 5'd7, 32'hDEADBEEF, 32'h407302B3, 1'b0);
    tv[7]  = mk(3'd0, 7'h13, 3'd0, 7'h00, 5'd1,  5'd0, 5'd0, 32'hFFFFF800, 32'h80000093, 1'b0);
    tv[8]  = mk(3'd0, 7'h13, 3'd0, 7'h00, 5'd1,  5'd0, 5'd0, 32'h00000800, 32'h80000093, 1'b1);
    tv[9]  = mk(3'd2, 7'h63, 3'd0, 7'h00, 5'd0,  5'd0, 5'd0, 32'h00000003, 32'h00000163, 1'b1);
    tv[10] = mk(3'd3, 7'h6F, 3'd0, 7'h00, 5'd0,  5'd0, 5'd0, 32'h00100000, 32'h8000006F, 1'b1);
    tv[11] = mk(3'd5, 7'h13, 3'd1, 7'h00, 5'd0,  5'd0, 5'd0, 32'h00000020, 32'h00001013, 1'b1);
    tv[12] = mk(3'd7, 7'h13, 3'd0, 7'h00, 5'd1,  5'd2, 5'd3, 32'h00000005, 32'h00000000, 1'b1);
    tv[13] = mk(3'd4, 7'h37, 3'd0, 7'h00, 5'd5,  5'd0, 5'd0, 32'h12345001, 32'h123452B7, 1'b1);
    tv[14] = mk(3'd3, 7'h6F, 3'd0, 7'h00, 5'd0,  5'd0, 5'd0, 32'h000FFFFE, 32'h7FFFF06F, 1'b0);
    tv[15] = mk(3'd2, 7'h63, 3'd0, 7'h00, 5'd0,  5'd0, 5'd0, 32'hFFFFF000, 32'h80000063, 1'b0);

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    load(0);

    #1 rst = 1'b1;
    #2;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'd0);
    chk("rst_out_err", {31'd0, bus.out_err}, 32'd0);
    chk("rst_out_addr", {30'd0, bus.out_addr}, 32'd0);
    chk("rst_err_cnt", {29'd0, err_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Table pass with the consumer always ready; first entry also checks latency.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) chk("pre_out_valid", {31'd0, bus.out_valid}, 32'd0);
      send(i);
      if (i == 0) chk("lat_out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    drain();
    chk("err_cnt_table", {29'd0, err_cnt}, {29'd0, m_err});

    // Saturation of the error counter.
    send(12);
    send(12);
    drain();
    chk("err_cnt_sat", {29'd0, err_cnt}, 32'd7);
    chk("err_cnt_model", {29'd0, err_cnt}, {29'd0, m_err});

    // Backpressure: two words fill the FIFO, the third waits for a pop.
    bus.out_ready = 1'b0;
    send(0);
    send(1);
    chk("bp_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
    load(2);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_no_accept", {31'd0, acc}, 32'd0);
      chk("bp_head_held", bus.out_inst, 32'hFFF00093);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_pop_same_cycle", {31'd0, bus.in_ready}, 32'd0);
    cyc();
    chk("bp_no_accept_at_pop", {31'd0, acc}, 32'd0);
    chk("bp_in_ready_after_pop", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b0;
    cyc();
    chk("bp_third_accepted", {31'd0, acc}, 32'd1);
    bus.in_valid = 1'b0;
    drain();

    // Flush with a coincident push, then wrap the 2-bit address.
    bus.out_ready = 1'b0;
    send(3);
    send(4);
    load(5);
    bus.in_valid = 1'b1;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("flush_err_cnt_kept", {29'd0, err_cnt}, 32'd7);
    bus.out_ready = 1'b1;
    send(6);
    chk("flush_first_addr", {30'd0, bus.out_addr}, 32'd0);
    send(7);
    send(14);
    send(15);
    send(5);
    drain();

    // Asynchronous reset with two words queued.
    bus.out_ready = 1'b0;
    send(0);
    send(1);
    chk("ar_full", {31'd0, bus.in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("ar_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("ar_err_cnt", {29'd0, err_cnt}, 32'd0);
    chk("ar_out_addr", {30'd0, bus.out_addr}, 32'd0);
    q.delete();
    m_addr = '0;
    m_err = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc();
    chk("ar_idle_out_valid", {31'd0, bus.out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
